// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, the default ack timeout and a counter-width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_DM = 2'd1,
        GNT_IF = 2'd2
    } arb_state_t;

    localparam int DEF_MAX_WAIT = 255;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Saturating wait counter for an outstanding memory grant. terminal flags the
// enabled cycle whose increment lands on (or sits at) MAX_COUNT.
module arb_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_COUNT = DEF_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam int CW = cnt_width(MAX_COUNT);
    localparam logic [CW-1:0] MAX_VAL = CW'(MAX_COUNT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != MAX_VAL)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Asserted one cycle early so the sticky error registers on the same edge
    // the count reaches its limit.
    assign terminal = en && !clr && (count_reg >= (MAX_VAL - 1'b1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between instruction fetch and the
// data load/store port; data wins, results are held until the pipeline advances.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    arb_state_t        state_reg;
    logic              if_done_reg;
    logic              dm_done_reg;
    logic              err_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] dm_rdata_reg;

    logic dm_pend;
    logic if_pend;
    logic stall;
    logic grant_dm;
    logic grant_if;
    logic wait_en;
    logic wait_terminal;

    assign dm_pend = dm_read_i | dm_write_i;
    assign if_pend = if_req_i;
    assign stall   = (dm_pend & ~dm_done_reg) | (if_pend & ~if_done_reg);

    // An undone data access blocks the fetch grant in the same IDLE cycle.
    assign grant_dm = (state_reg == IDLE) & dm_pend & ~dm_done_reg;
    assign grant_if = (state_reg == IDLE) & ~grant_dm & if_pend & ~if_done_reg;
    assign wait_en  = (state_reg != IDLE) & ~mem_ack_i;

    arb_wait_counter #(
        .MAX_COUNT(MAX_WAIT)
    ) u_wait_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (grant_dm | grant_if),
        .en       (wait_en),
        .terminal (wait_terminal)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            if_done_reg   <= 1'b0;
            dm_done_reg   <= 1'b0;
            err_reg       <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
        end else begin
            // Pipeline advanced: release held results. Sets below override.
            if (!stall) begin
                if_done_reg <= 1'b0;
                dm_done_reg <= 1'b0;
            end
            if (wait_terminal) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (grant_dm) begin
                        state_reg     <= GNT_DM;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= dm_write_i;
                        mem_addr_reg  <= dm_addr_i;
                        mem_wdata_reg <= dm_wdata_i;
                    end else if (grant_if) begin
                        state_reg    <= GNT_IF;
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= if_addr_i;
                    end
                end
                GNT_DM: begin
                    if (mem_ack_i) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        // A flushed request discards the returned data.
                        if (dm_pend) begin
                            dm_done_reg <= 1'b1;
                            if (!mem_we_reg) begin
                                dm_rdata_reg <= mem_rdata_i;
                            end
                        end
                    end
                end
                GNT_IF: begin
                    if (mem_ack_i) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        if (if_pend) begin
                            if_done_reg  <= 1'b1;
                            if_rdata_reg <= mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_reg;
    assign if_ready_o  = if_done_reg;
    assign dm_rdata_o  = dm_rdata_reg;
    assign dm_ready_o  = dm_done_reg;
    assign mem_req_o   = mem_req_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign stall_o     = stall;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus queues expected grants
// and returned words; a negedge monitor pops and compares them as they appear.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        err;

    mem_txn_t    mem_q[$];
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    logic [31:0] mem_model [logic [31:0]];

    int total = 0;
    int bad   = 0;
    bit auto_ack = 1'b0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit prev_req = 1'b0;
    bit prev_if  = 1'b0;
    bit prev_dm  = 1'b0;
    int cyc;
    bit got;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_ready_o  (if_ready),
        .dm_read_i   (dm_read),
        .dm_write_i  (dm_write),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_ready_o  (dm_ready),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .stall_o     (stall),
        .err_o       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after ack_delay waiting grant cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!mem_req) begin
                wait_cnt = 0;
            end else if (auto_ack) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_model[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hBAD0_0000;
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: each new grant and each newly ready word is matched to the scoreboard.
    initial begin
        mem_txn_t    exp_t;
        logic [31:0] exp_w;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                if (mem_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got addr 0x%08h want none", mem_addr);
                end else begin
                    exp_t = mem_q.pop_front();
                    chk("grant_addr", mem_addr, exp_t.addr);
                    chk1("grant_we", mem_we, exp_t.we);
                    if (exp_t.we) chk("grant_wdata", mem_wdata, exp_t.wdata);
                end
            end
            if (if_ready && !prev_if) begin
                if (if_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_if_ready: got 0x%08h want none", if_rdata);
                end else begin
                    exp_w = if_q.pop_front();
                    chk("if_rdata", if_rdata, exp_w);
                end
            end
            if (dm_ready && !prev_dm) begin
                if (dm_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dm_ready: got 0x%08h want none", dm_rdata);
                end else begin
                    exp_w = dm_q.pop_front();
                    chk("dm_rdata", dm_rdata, exp_w);
                end
            end
            prev_req = mem_req;
            prev_if  = if_ready;
            prev_dm  = dm_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        mem_model[32'h0000_0100] = 32'h2002_0005;
        mem_model[32'h0000_0010] = 32'h1111_0010;
        mem_model[32'h0000_0104] = 32'h2222_0104;
        mem_model[32'h0000_0200] = 32'h3333_0200;
        mem_model[32'h0000_0030] = 32'h4444_0030;

        // Reset state
        #12;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_dm_ready", dm_ready, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // 1: fetch only; grant at E1, ack in third grant cycle, ready at 5th negedge
        auto_ack  = 1'b1;
        ack_delay = 2;
        mem_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
        if_q.push_back(32'h2002_0005);
        if_req  = 1'b1;
        if_addr = 32'h100;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (if_ready) got = 1'b1;
            else chk1("t1_stall_busy", stall, 1'b1);
        end
        chk("t1_latency", 32'(cyc), 32'd5);
        chk1("t1_stall_done", stall, 1'b0);
        step(1);
        if_req = 1'b0;
        @(negedge clk);
        chk1("t1_ready_cleared", if_ready, 1'b0);

        // 2: fetch and load together; DM first, one IDLE gap, then IF
        step(1);
        ack_delay = 0;
        mem_q.push_back('{addr: 32'h10, we: 1'b0, wdata: 32'h0});
        mem_q.push_back('{addr: 32'h104, we: 1'b0, wdata: 32'h0});
        dm_q.push_back(32'h1111_0010);
        if_q.push_back(32'h2222_0104);
        dm_read = 1'b1;
        dm_addr = 32'h10;
        if_req  = 1'b1;
        if_addr = 32'h104;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!stall) got = 1'b1;
        end
        chk("t2_stall_cycles", 32'(cyc), 32'd5);
        chk1("t2_dm_ready", dm_ready, 1'b1);
        chk1("t2_if_ready", if_ready, 1'b1);
        step(1);
        dm_read = 1'b0;
        if_req  = 1'b0;
        @(negedge clk);
        chk1("t2_dm_ready_cleared", dm_ready, 1'b0);

        // 3: store with ack in first grant cycle; load data register keeps old word
        step(1);
        mem_q.push_back('{addr: 32'h20, we: 1'b1, wdata: 32'hDEAD_BEEF});
        dm_q.push_back(32'h1111_0010);
        dm_write = 1'b1;
        dm_addr  = 32'h20;
        dm_wdata = 32'hDEAD_BEEF;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (dm_ready) got = 1'b1;
        end
        chk("t3_latency", 32'(cyc), 32'd3);
        chk1("t3_stall", stall, 1'b0);
        step(1);
        dm_write = 1'b0;
        chk("t3_mem_written", mem_model.exists(32'h20) ? mem_model[32'h20] : 32'h0, 32'hDEAD_BEEF);

        // 4: fetch dropped while granted; data discarded
        step(1);
        ack_delay = 3;
        mem_q.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
        if_req  = 1'b1;
        if_addr = 32'h200;
        step(1);
        if_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1("t4_no_ready", if_ready, 1'b0);
        end
        chk1("t4_back_idle", mem_req, 1'b0);
        chk("t4_if_rdata_kept", if_rdata, 32'h2222_0104);
        chk1("t4_no_err", err, 1'b0);

        // 5: no ack; err rises once four grant cycles have elapsed, late ack completes
        step(1);
        auto_ack = 1'b0;
        mem_q.push_back('{addr: 32'h30, we: 1'b0, wdata: 32'h0});
        dm_q.push_back(32'h4444_0030);
        dm_read = 1'b1;
        dm_addr = 32'h30;
        step(1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk1("t5_req_held", mem_req, 1'b1);
            chk1("t5_err", err, (k >= 5));
        end
        ack_delay = 0;
        auto_ack  = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (dm_ready) got = 1'b1;
        end
        chk1("t5_late_ack_done", got, 1'b1);
        chk1("t5_err_sticky", err, 1'b1);
        step(1);
        dm_read = 1'b0;

        // 6: async reset while in GNT_DM
        step(1);
        auto_ack = 1'b0;
        mem_q.push_back('{addr: 32'h10, we: 1'b0, wdata: 32'h0});
        dm_read = 1'b1;
        dm_addr = 32'h10;
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_mem_req", mem_req, 1'b0);
        chk1("t6_rst_dm_ready", dm_ready, 1'b0);
        chk1("t6_rst_err", err, 1'b0);
        dm_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("t6_idle_no_req", mem_req, 1'b0);
        end
        // A fresh load must start from IDLE with normal latency
        step(1);
        auto_ack  = 1'b1;
        ack_delay = 0;
        mem_q.push_back('{addr: 32'h104, we: 1'b0, wdata: 32'h0});
        dm_q.push_back(32'h2222_0104);
        dm_read = 1'b1;
        dm_addr = 32'h104;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (dm_ready) got = 1'b1;
        end
        chk("t6_post_rst_latency", 32'(cyc), 32'd3);
        step(1);
        dm_read = 1'b0;
        step(2);

        chk("sb_mem_q_empty", 32'(mem_q.size()), 32'd0);
        chk("sb_if_q_empty", 32'(if_q.size()), 32'd0);
        chk("sb_dm_q_empty", 32'(dm_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
